// File: rtl/ooocpu_pkg.sv
`default_nettype none
// ooocpu_pkg -- shared out-of-order core sizes, rename FSM state type, tag-width helper.
// Rev 1.0
`ifndef ROB_DEPTH
`define ROB_DEPTH 8
`endif
`ifndef GPR_ADDR_WIDTH
`define GPR_ADDR_WIDTH 5
`endif

package ooocpu_pkg;

  localparam int ROB_TAG_W = $clog2(`ROB_DEPTH);
  localparam int ROB_CNT_W = ROB_TAG_W + 1;
  localparam int RCNT_W    = 4;

  typedef enum logic [1:0] {
    RN_RUN     = 2'd0,
    RN_FLUSH   = 2'd1,
    RN_RECOVER = 2'd2
  } rn_state_e;

  function automatic int tag_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rob_ptr.sv
`default_nettype none
// rob_ptr -- modulo-DEPTH ROB pointer with clear (priority) and increment.
// Rev 1.0
module rob_ptr
  import ooocpu_pkg::*;
#(
  parameter int DEPTH = `ROB_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr_i,
  input  logic                        inc_i,
  output logic [$clog2(DEPTH)-1:0]    ptr_o
);

  logic [$clog2(DEPTH)-1:0] ptr_q;

  // DEPTH is a power of two, so the natural binary wrap is the modulo.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (clr_i) begin
      ptr_q <= '0;
    end else if (inc_i) begin
      ptr_q <= ptr_q + 1'b1;
    end
  end

  assign ptr_o = ptr_q;

endmodule

`default_nettype wire

// File: rtl/rename_ctrl.sv
`default_nettype none
// rename_ctrl -- rename allocation controller: ROB head/tail/count, flush and recovery stall.
// Rev 1.0. Optional macro RENAME_PERF_EN adds saturating full-stall and flush counters.
module rename_ctrl
  import ooocpu_pkg::*;
#(
  parameter int ROB_DEPTH      = `ROB_DEPTH,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              id_valid,
  input  logic [`GPR_ADDR_WIDTH-1:0]        id_dst_addr,
  input  logic                              id_dst_wen,
  output logic                              id_ready,
  output logic                              allocate_en,
  output logic [$clog2(ROB_DEPTH)-1:0]      rob_alloc_tag_2rat,
  output logic [`GPR_ADDR_WIDTH-1:0]        rob_alloc_dst_addr_2rat,
  output logic                              rob_alloc_dst_wen_2rat,
  input  logic                              commit_en,
  input  logic                              rob_commit_br_taken,
  input  logic                              rob_commit_exp_en,
  output logic [$clog2(ROB_DEPTH)-1:0]      rob_head_tag,
  output logic [$clog2(ROB_DEPTH):0]        rob_count,
`ifdef RENAME_PERF_EN
  output logic [31:0]                       perf_full_stall_cnt,
  output logic [31:0]                       perf_flush_cnt,
`endif
  output logic                              rename_full,
  output logic                              rename_empty,
  output logic                              err_underflow
);

  localparam int TAG_W = tag_width(ROB_DEPTH);
  localparam int CNT_W = TAG_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(ROB_DEPTH);
  localparam logic [RCNT_W-1:0] RCNT_C  = RCNT_W'(RECOVER_CYCLES);

  rn_state_e          state_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic [RCNT_W-1:0]  rcnt_q;
  logic               underflow_q;
  logic               flush_req;
  logic               commit_ok;
  logic               ptr_clr;
  logic [TAG_W-1:0]   head;
  logic [TAG_W-1:0]   tail;

  assign flush_req   = rob_commit_br_taken | rob_commit_exp_en;
  assign id_ready    = (state_q == RN_RUN) && (count_q < DEPTH_C);
  assign allocate_en = id_valid && id_ready && !flush_req;
  assign commit_ok   = (state_q == RN_RUN) && commit_en && !flush_req && (count_q != '0);
  assign ptr_clr     = (state_q == RN_FLUSH);
  assign count_d     = count_q + CNT_W'(allocate_en) - CNT_W'(commit_ok);

  rob_ptr #(.DEPTH(ROB_DEPTH)) u_head (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (ptr_clr),
    .inc_i (commit_ok),
    .ptr_o (head)
  );

  rob_ptr #(.DEPTH(ROB_DEPTH)) u_tail (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (ptr_clr),
    .inc_i (allocate_en),
    .ptr_o (tail)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RN_RUN;
      count_q     <= '0;
      rcnt_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      case (state_q)
        RN_RUN: begin
          if (flush_req) begin
            state_q <= RN_FLUSH;
          end else begin
            count_q <= count_d;
            if (commit_en && (count_q == '0)) underflow_q <= 1'b1;
          end
        end
        RN_FLUSH: begin
          count_q <= '0;
          rcnt_q  <= RCNT_C;
          state_q <= RN_RECOVER;
        end
        RN_RECOVER: begin
          // A new flush during recovery restarts the full stall window.
          if (flush_req) begin
            rcnt_q <= RCNT_C;
          end else if (rcnt_q <= 4'd1) begin
            rcnt_q  <= '0;
            state_q <= RN_RUN;
          end else begin
            rcnt_q <= rcnt_q - 1'b1;
          end
        end
        default: state_q <= RN_RUN;
      endcase
    end
  end

`ifdef RENAME_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (id_valid && (state_q == RN_RUN) && (count_q == DEPTH_C) && (perf_stall_q != '1))
        perf_stall_q <= perf_stall_q + 1'b1;
      if ((state_q == RN_RUN) && flush_req && (perf_flush_q != '1))
        perf_flush_q <= perf_flush_q + 1'b1;
    end
  end

  assign perf_full_stall_cnt = perf_stall_q;
  assign perf_flush_cnt      = perf_flush_q;
`endif

  assign rob_alloc_tag_2rat      = tail;
  assign rob_alloc_dst_addr_2rat = id_dst_addr;
  assign rob_alloc_dst_wen_2rat  = id_dst_wen && (id_dst_addr != '0);
  assign rob_head_tag            = head;
  assign rob_count               = count_q;
  assign rename_full             = (count_q == DEPTH_C);
  assign rename_empty            = (count_q == '0);
  assign err_underflow           = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_rename_ctrl.sv
`default_nettype none
// tb_rename_ctrl -- directed self-checking bench for rename_ctrl (ROB_DEPTH 8, RECOVER_CYCLES 2).
// Rev 1.0
module tb_rename_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_dst_addr;
  logic       id_dst_wen;
  logic       id_ready;
  logic       allocate_en;
  logic [2:0] rob_alloc_tag_2rat;
  logic [4:0] rob_alloc_dst_addr_2rat;
  logic       rob_alloc_dst_wen_2rat;
  logic       commit_en;
  logic       rob_commit_br_taken;
  logic       rob_commit_exp_en;
  logic [2:0] rob_head_tag;
  logic [3:0] rob_count;
  logic       rename_full;
  logic       rename_empty;
  logic       err_underflow;
`ifdef RENAME_PERF_EN
  logic [31:0] perf_full_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rename_ctrl #(.ROB_DEPTH(8), .RECOVER_CYCLES(2)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .id_valid                (id_valid),
    .id_dst_addr             (id_dst_addr),
    .id_dst_wen              (id_dst_wen),
    .id_ready                (id_ready),
    .allocate_en             (allocate_en),
    .rob_alloc_tag_2rat      (rob_alloc_tag_2rat),
    .rob_alloc_dst_addr_2rat (rob_alloc_dst_addr_2rat),
    .rob_alloc_dst_wen_2rat  (rob_alloc_dst_wen_2rat),
    .commit_en               (commit_en),
    .rob_commit_br_taken     (rob_commit_br_taken),
    .rob_commit_exp_en       (rob_commit_exp_en),
    .rob_head_tag            (rob_head_tag),
    .rob_count               (rob_count),
`ifdef RENAME_PERF_EN
    .perf_full_stall_cnt     (perf_full_stall_cnt),
    .perf_flush_cnt          (perf_flush_cnt),
`endif
    .rename_full             (rename_full),
    .rename_empty            (rename_empty),
    .err_underflow           (err_underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; id_dst_addr = '0; id_dst_wen = 1'b0;
    commit_en = 1'b0; rob_commit_br_taken = 1'b0; rob_commit_exp_en = 1'b0;
    tick(); tick();
    settle();
    chk("rst_id_ready", id_ready, 1);
    chk("rst_alloc_en", allocate_en, 0);
    chk("rst_empty", rename_empty, 1);
    chk("rst_full", rename_full, 0);
    chk("rst_head", rob_head_tag, 0);
    chk("rst_count", rob_count, 0);
    chk("rst_underflow", err_underflow, 0);
    rst_n = 1'b1;
    tick();

    // Eight back-to-back allocations fill the ROB.
    for (int i = 0; i < 8; i++) begin
      id_valid = 1'b1; id_dst_addr = 5'(i + 1); id_dst_wen = 1'b1;
      settle();
      chk("fill_alloc_en", allocate_en, 1);
      chk("fill_tag", rob_alloc_tag_2rat, i);
      chk("fill_dst_addr", rob_alloc_dst_addr_2rat, i + 1);
      chk("fill_dst_wen", rob_alloc_dst_wen_2rat, 1);
      tick();
    end
    settle();
    chk("full_count", rob_count, 8);
    chk("full_flag", rename_full, 1);
    chk("full_id_ready", id_ready, 0);
    chk("full_alloc_en", allocate_en, 0);

    // Commit while full does not open the gate in the same cycle.
    commit_en = 1'b1;
    settle();
    chk("full_commit_alloc_en", allocate_en, 0);
    chk("full_commit_ready", id_ready, 0);
    tick();
    commit_en = 1'b0;
    settle();
    chk("after_commit_count", rob_count, 7);
    chk("after_commit_head", rob_head_tag, 1);
    chk("wrap_alloc_en", allocate_en, 1);
    chk("wrap_tag", rob_alloc_tag_2rat, 0);
    tick();
    settle();
    chk("wrap_count", rob_count, 8);

    // Drain to three entries: head 1 -> 6.
    id_valid = 1'b0;
    commit_en = 1'b1;
    repeat (5) tick();
    commit_en = 1'b0;
    settle();
    chk("drain_count", rob_count, 3);
    chk("drain_head", rob_head_tag, 6);

    // Allocate and commit together.
    id_valid = 1'b1; commit_en = 1'b1; id_dst_addr = 5'd7;
    settle();
    chk("both_alloc_en", allocate_en, 1);
    chk("both_tag", rob_alloc_tag_2rat, 1);
    tick();
    id_valid = 1'b0; commit_en = 1'b0;
    settle();
    chk("both_count", rob_count, 3);
    chk("both_head", rob_head_tag, 7);
    chk("both_tail", rob_alloc_tag_2rat, 2);

    // x0 destination still allocates but suppresses the write enable.
    id_valid = 1'b1; id_dst_addr = 5'd0; id_dst_wen = 1'b1;
    settle();
    chk("x0_alloc_en", allocate_en, 1);
    chk("x0_tag", rob_alloc_tag_2rat, 2);
    chk("x0_wen", rob_alloc_dst_wen_2rat, 0);
    tick();
    id_dst_addr = 5'd9;
    settle();
    chk("x9_wen", rob_alloc_dst_wen_2rat, 1);
    chk("x9_tag", rob_alloc_tag_2rat, 3);
    tick();
    settle();
    chk("pre_flush_count", rob_count, 5);

    // Exception flush with id_valid held high.
    rob_commit_exp_en = 1'b1; commit_en = 1'b1;
    settle();
    chk("exp_alloc_en", allocate_en, 0);
    tick();
    rob_commit_exp_en = 1'b0;
    settle();
    chk("flush_ready", id_ready, 0);
    chk("flush_alloc_en", allocate_en, 0);
    tick();
    commit_en = 1'b0;
    settle();
    chk("rec1_count", rob_count, 0);
    chk("rec1_head", rob_head_tag, 0);
    chk("rec1_ready", id_ready, 0);
    tick();
    settle();
    chk("rec2_ready", id_ready, 0);
    tick();
    settle();
    chk("run_ready", id_ready, 1);
    chk("run_alloc_en", allocate_en, 1);
    chk("run_first_tag", rob_alloc_tag_2rat, 0);
    chk("run_underflow", err_underflow, 0);
    tick();
    id_valid = 1'b0;
    settle();
    chk("run_count", rob_count, 1);

    // Branch flush, then a second flush late in recovery restarts the stall.
    rob_commit_br_taken = 1'b1;
    tick();
    rob_commit_br_taken = 1'b0;
    tick();
    tick();
    rob_commit_br_taken = 1'b1;
    settle();
    chk("restart_pre_ready", id_ready, 0);
    tick();
    rob_commit_br_taken = 1'b0;
    settle();
    chk("restart_r1_ready", id_ready, 0);
    tick();
    settle();
    chk("restart_r2_ready", id_ready, 0);
    tick();
    settle();
    chk("restart_run_ready", id_ready, 1);

    // Reset during recovery returns straight to RUN.
    rob_commit_br_taken = 1'b1;
    tick();
    rob_commit_br_taken = 1'b0;
    tick();
    settle();
    chk("midrec_ready", id_ready, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    settle();
    chk("abort_ready", id_ready, 1);
    chk("abort_empty", rename_empty, 1);

    // Commit on an empty ROB sets the sticky underflow flag.
    commit_en = 1'b1;
    tick();
    commit_en = 1'b0;
    settle();
    chk("uf_flag", err_underflow, 1);
    chk("uf_count", rob_count, 0);
    chk("uf_head", rob_head_tag, 0);
    tick(); tick();
    settle();
    chk("uf_held", err_underflow, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rename_ctrl.md
RENAME_CTRL -- requirements
Module: rename_ctrl

Interface
REQ-001 SHALL take parameter ROB_DEPTH, default `ROB_DEPTH (8), number of ROB tags; a power of two and at least 2.
REQ-002 SHALL take parameter RECOVER_CYCLES, default 2, number of dead cycles after a flush before allocation resumes; range 1..15.
REQ-003 SHALL have one clock; reset is synchronous and active-low; ports clk and rst_n.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 id_valid  input  1  decode presents an instruction to rename.
REQ-007 id_dst_addr  input  `GPR_ADDR_WIDTH  architectural destination.
REQ-008 id_dst_wen  input  1  instruction writes a GPR.
REQ-009 id_ready  output  1  controller accepts this cycle.
REQ-010 allocate_en  output  1  pulse to RAT/ROB.
REQ-011 rob_alloc_tag_2rat  output  $clog2(ROB_DEPTH)  allocated tag.
REQ-012 rob_alloc_dst_addr_2rat  output  `GPR_ADDR_WIDTH  pass-through of id_dst_addr.
REQ-013 rob_alloc_dst_wen_2rat  output  1  id_dst_wen AND (id_dst_addr != 0).
REQ-014 commit_en  input  1  ROB retires the head entry.
REQ-015 rob_commit_br_taken, rob_commit_exp_en  input  1 each  flush requests.
REQ-016 rob_head_tag  output  $clog2(ROB_DEPTH)  oldest live tag.
REQ-017 rob_count  output  $clog2(ROB_DEPTH)+1  live entries.
REQ-018 rename_full, rename_empty  output  1 each  derived from rob_count.
REQ-019 err_underflow  output  1  sticky flag: commit_en seen while empty.

Function
REQ-020 SHALL implement FSM RUN, FLUSH, RECOVER; reset state RUN.
REQ-021 id_ready SHALL be 1 only in RUN with registered rob_count < ROB_DEPTH; a commit in the same cycle SHALL NOT make a full controller ready.
REQ-022 Handshake: allocate_en = id_valid AND id_ready, combinational, same cycle; rob_alloc_tag_2rat = tail pointer.
REQ-023 On allocate_en, tail SHALL increment modulo ROB_DEPTH at the next edge (wraps ROB_DEPTH-1 -> 0).
REQ-024 On commit_en in RUN with count > 0, head SHALL increment modulo ROB_DEPTH.
REQ-025 On simultaneous allocate and commit, count SHALL be unchanged and both pointers SHALL advance.
REQ-026 On commit_en with count = 0, count and head SHALL be unchanged and err_underflow SHALL set until reset.
REQ-027 rob_commit_br_taken or rob_commit_exp_en in RUN SHALL take priority over allocate and commit: allocate_en is forced to 0 that cycle and the FSM enters FLUSH.
REQ-028 FLUSH (1 cycle): head, tail and count SHALL be cleared to 0, id_ready = 0, commit_en ignored, next state RECOVER.
REQ-029 RECOVER: id_ready = 0 for RECOVER_CYCLES cycles counted by a down-counter, then RUN.
REQ-030 Flush requests in FLUSH or RECOVER SHALL restart RECOVER with a full count.

Reset
REQ-031 While rst_n = 0 at a clk edge: state RUN, head = tail = count = 0, err_underflow = 0, recover counter = 0.
REQ-032 Reset values of outputs: id_ready = 1, allocate_en = 0 (given id_valid = 0), rename_empty = 1, rename_full = 0, rob_head_tag = 0.
REQ-033 Reset asserted mid-flush or mid-recover SHALL abort to RUN with no residual stall.

Configuration
REQ-034 Macro RENAME_PERF_EN: when defined, SHALL add outputs perf_full_stall_cnt and perf_flush_cnt (32 bits each, saturating). perf_full_stall_cnt increments on id_valid AND full in RUN; perf_flush_cnt increments on FLUSH entry; both reset to 0.
REQ-035 Without RENAME_PERF_EN, those ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-036 ROB tag width, count width and the FSM state enum SHALL live in the shared ooocpu package alongside `ROB_DEPTH and `GPR_ADDR_WIDTH.
REQ-037 SHALL instantiate one sub-module, rob_ptr (a modulo-ROB_DEPTH pointer with increment and clear), twice: once for head and once for tail.

Verification
REQ-038 ROB_DEPTH = 8: 8 back-to-back allocations -> tags 0..7, rename_full = 1, id_ready = 0 on the 9th cycle.
REQ-039 Full, then commit_en and id_valid in the same cycle -> no allocation that cycle; next cycle tag 0 is allocated (wrap), count = 8.
REQ-040 count = 3, allocate and commit together -> count stays 3, head +1, tail +1.
REQ-041 rob_commit_exp_en with count = 5 and id_valid = 1 -> allocate_en = 0; after FLUSH count = 0; id_ready = 0 for exactly 2 RECOVER cycles, then 1; first new tag is 0.
REQ-042 commit_en while empty -> err_underflow = 1 and held; count = 0.
REQ-043 id_dst_addr = 0 with id_dst_wen = 1 -> rob_alloc_dst_wen_2rat = 0 while a tag is still allocated.
